// File: rtl/dmg_fb_if.sv
// dmg_fb_if: host write handshake and framebuffer RAM bus used by dmg_fb_scheduler.
//   host_valid/host_addr/host_data -> scheduler, host_ready <- scheduler
//   mem_addr/mem_we/mem_wdata      <- scheduler (registered), mem_rdata -> scheduler
// slave  : the scheduler side.
// master : the host + RAM side (testbench or SoC glue).
interface dmg_fb_if #(
    parameter int AW = 13
);
    logic          host_valid;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_data;
    logic          host_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    modport slave (
        input  host_valid, host_addr, host_data, mem_rdata,
        output host_ready, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output host_valid, host_addr, host_data, mem_rdata,
        input  host_ready, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/dmg_fb_scheduler.sv
// dmg_fb_scheduler: arbitrates a single-port 2bpp framebuffer RAM between LCD
// scan-out prefetch (always wins) and host pixel writes (take every spare cycle).
// Prefetched bytes go through a small FIFO into a 2-bit/pixel shifter.
//
// Ports:
//   clk_8m, rst       clock, asynchronous active-high reset
//   line_start/line_y start fetching line line_y (y >= V_PIX just flushes)
//   pix_adv           consumer advanced past the current pixel
//   pix/pix_valid     current pixel (2'b11 when not valid)
//   underrun          sticky: pix_adv with no pixel; cleared by a visible line_start
//   underrun_cnt      saturating underrun counter (only with DMG_FB_STATS_EN)
//   bus               dmg_fb_if.slave: host write handshake and RAM port
//
// Optional feature macro: DMG_FB_STATS_EN
module dmg_fb_scheduler #(
    parameter int H_PIX      = 160,
    parameter int V_PIX      = 160,
    parameter int FIFO_DEPTH = 4,   // power of 2, >= 2
    parameter int AW         = 13
) (
    input  logic        clk_8m,
    input  logic        rst,
    input  logic        line_start,
    input  logic [7:0]  line_y,
    input  logic        pix_adv,
    output logic [1:0]  pix,
    output logic        pix_valid,
    output logic        underrun,
`ifdef DMG_FB_STATS_EN
    output logic [15:0] underrun_cnt,
`endif
    dmg_fb_if.slave     bus
);
    localparam int BPL    = H_PIX / 4;
    localparam int NBYTES = H_PIX * V_PIX / 4;
    localparam int RW     = $clog2(BPL + 1);
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = $clog2(FIFO_DEPTH + 1);

    logic [AW-1:0] fetch_addr;
    logic [RW-1:0] remain;
    logic          inflight;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_count;
    logic [7:0]    shifter;
    logic [2:0]    sh_cnt;
    logic          ready_en;

    logic line_ok, fetch_need, push, pop, host_xfer, host_in_range, adv_empty;

    assign line_ok       = 32'(line_y) < 32'(V_PIX);
    // Count the byte already on its way from RAM so the FIFO never overflows.
    assign fetch_need    = (remain != '0) &&
                           (({1'b0, fifo_count} + (CW+1)'(inflight)) < (CW+1)'(FIFO_DEPTH));
    // ready_en keeps host_ready low through reset while staying a pure flop output.
    assign bus.host_ready = ready_en && !fetch_need;
    assign host_xfer     = bus.host_valid && bus.host_ready;
    assign host_in_range = 32'(bus.host_addr) < 32'(NBYTES);
    // line_start flushes: the in-flight byte is dropped and pix_adv is ignored.
    assign push          = inflight && !line_start;
    assign pop           = (sh_cnt == 3'd0) && (fifo_count != '0) && !line_start;
    assign adv_empty     = pix_adv && !line_start && (sh_cnt == 3'd0);

    assign pix_valid = (sh_cnt != 3'd0);
    assign pix       = pix_valid ? shifter[7:6] : 2'b11;

    always_ff @(posedge clk_8m or posedge rst) begin
        if (rst) ready_en <= 1'b0;
        else     ready_en <= 1'b1;
    end

    always_ff @(posedge clk_8m or posedge rst) begin
        if (rst) begin
            fetch_addr <= '0;
            remain     <= '0;
            inflight   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            shifter    <= '0;
            sh_cnt     <= 3'd0;
            underrun   <= 1'b0;
        end else if (line_start) begin
            inflight   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            shifter    <= '0;
            sh_cnt     <= 3'd0;
            if (line_ok) begin
                fetch_addr <= AW'(32'(line_y) * 32'(BPL));
                remain     <= RW'(BPL);
                underrun   <= 1'b0;
            end else begin
                remain     <= '0;
            end
        end else begin
            inflight <= fetch_need;
            if (fetch_need) begin
                fetch_addr <= fetch_addr + 1'b1;
                remain     <= remain - 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
            // pop needs sh_cnt==0 and shifting needs sh_cnt!=0: never both.
            if (pop) begin
                shifter <= fifo_mem[rd_ptr];
                sh_cnt  <= 3'd4;
            end else if (pix_adv && sh_cnt != 3'd0) begin
                shifter <= {shifter[5:0], 2'b00};
                sh_cnt  <= sh_cnt - 1'b1;
            end
            if (adv_empty) underrun <= 1'b1;
        end
    end

    always_ff @(posedge clk_8m) begin
        if (push) fifo_mem[wr_ptr] <= bus.mem_rdata;
    end

    // RAM port: fetch and host transfers are exclusive because host_ready = !fetch_need.
    always_ff @(posedge clk_8m or posedge rst) begin
        if (rst) begin
            bus.mem_addr  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_wdata <= 8'h00;
        end else begin
            bus.mem_we <= 1'b0;
            if (fetch_need && !line_start) begin
                bus.mem_addr <= fetch_addr;
            end else if (host_xfer && host_in_range) begin
                bus.mem_addr  <= bus.host_addr;
                bus.mem_we    <= 1'b1;
                bus.mem_wdata <= bus.host_data;
            end
        end
    end

`ifdef DMG_FB_STATS_EN
    always_ff @(posedge clk_8m or posedge rst) begin
        if (rst)                                     underrun_cnt <= 16'h0000;
        else if (adv_empty && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_dmg_fb_scheduler.sv
// tb_dmg_fb_scheduler: self-checking bench for dmg_fb_scheduler with a
// behavioural RAM (read data follows the registered address), a pixel
// scoreboard filled at line_start and a host-write scoreboard.
module tb_dmg_fb_scheduler;
    localparam int H_PIX = 160, V_PIX = 160, FIFO_DEPTH = 4, AW = 13;
    localparam int BPL = H_PIX / 4;

    logic       clk_8m = 1'b0;
    logic       rst = 1'b1;
    logic       line_start = 1'b0;
    logic [7:0] line_y = 8'd0;
    logic       pix_adv = 1'b0;
    logic [1:0] pix;
    logic       pix_valid, underrun;
`ifdef DMG_FB_STATS_EN
    logic [15:0] underrun_cnt;
`endif

    dmg_fb_if #(.AW(AW)) bus();

    logic [7:0] ram [0:8191];
    int n_checks = 0, n_fail = 0;
    logic [1:0] exp_pix [$];
    logic [AW+7:0] exp_wr [$];
    int rd_cnt = 0;
    logic rd_cnt_en = 1'b0;

    dmg_fb_scheduler #(.H_PIX(H_PIX), .V_PIX(V_PIX), .FIFO_DEPTH(FIFO_DEPTH), .AW(AW)) dut (
        .clk_8m(clk_8m), .rst(rst), .line_start(line_start), .line_y(line_y),
        .pix_adv(pix_adv), .pix(pix), .pix_valid(pix_valid), .underrun(underrun),
`ifdef DMG_FB_STATS_EN
        .underrun_cnt(underrun_cnt),
`endif
        .bus(bus)
    );

    always #5 clk_8m = ~clk_8m;

    assign bus.mem_rdata = ram[bus.mem_addr];
    always @(posedge clk_8m) if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    // Every cycle with host_ready low is a fetch cycle, so this counts RAM reads.
    always @(negedge clk_8m) if (rd_cnt_en && !bus.host_ready) rd_cnt <= rd_cnt + 1;

    task automatic tick();
        @(posedge clk_8m); #1;
    endtask

    task automatic start_line(input logic [7:0] y, input logic adv);
        line_start = 1'b1; line_y = y; pix_adv = adv;
        exp_pix.delete();
        if (y < V_PIX)
            for (int b = 0; b < BPL; b++) begin
                logic [7:0] v;
                v = ram[int'(y) * BPL + b];
                for (int p = 0; p < 4; p++) exp_pix.push_back(v[7-2*p -: 2]);
            end
        tick();
        line_start = 1'b0; pix_adv = 1'b0;
    endtask

    task automatic consume(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            logic [1:0] e;
            e = (exp_pix.size() != 0) ? exp_pix.pop_front() : 2'bxx;
            n_checks++;
            if (pix_valid !== 1'b1 || pix !== e) begin
                n_fail++;
                $display("FAIL %s[%0d]: got valid=%b pix=%b want valid=1 pix=%b", tag, i, pix_valid, pix, e);
            end
            pix_adv = 1'b1; tick(); pix_adv = 1'b0; tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick();
        n_checks++; if (pix !== 2'b11) begin n_fail++; $display("FAIL reset_pix: got %b want 11", pix); end
        n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid: got %b want 0", pix_valid); end
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        n_checks++; if (bus.mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %0d want 0", bus.mem_addr); end
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
        n_checks++; if (bus.mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 00", bus.mem_wdata); end
        n_checks++; if (bus.host_ready !== 1'b0) begin n_fail++; $display("FAIL reset_host_ready: got %b want 0", bus.host_ready); end
        rst = 1'b0; tick();
        n_checks++; if (bus.host_ready !== 1'b1) begin n_fail++; $display("FAIL idle_host_ready: got %b want 1", bus.host_ready); end
    endtask

    task automatic test_underrun_no_line();
        for (int i = 0; i < 3; i++) begin
            pix_adv = 1'b1; tick(); pix_adv = 1'b0; tick();
        end
        n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_set: got %b want 1", underrun); end
        n_checks++; if (pix !== 2'b11 || pix_valid !== 1'b0) begin n_fail++; $display("FAIL underrun_blank: got pix=%b valid=%b want 11/0", pix, pix_valid); end
`ifdef DMG_FB_STATS_EN
        n_checks++; if (underrun_cnt !== 16'd3) begin n_fail++; $display("FAIL underrun_cnt: got %0d want 3", underrun_cnt); end
`endif
    endtask

    task automatic test_fetch_burst();
        rd_cnt = 0; rd_cnt_en = 1'b1;
        start_line(8'd0, 1'b0);
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL line_clears_underrun: got %b want 0", underrun); end
        n_checks++; if (bus.host_ready !== 1'b0) begin n_fail++; $display("FAIL burst_ready_start: got %b want 0", bus.host_ready); end
        // Five reads: four bytes fill the FIFO and one lands in the shifter.
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (bus.mem_addr !== AW'(k) || bus.mem_we !== 1'b0 || bus.host_ready !== (k == 4)) begin
                n_fail++;
                $display("FAIL burst_read[%0d]: got addr=%0d we=%b ready=%b want addr=%0d we=0 ready=%b",
                         k, bus.mem_addr, bus.mem_we, bus.host_ready, k, (k == 4));
            end
            if (k == 2) begin
                n_checks++; if (pix_valid !== 1'b1) begin n_fail++; $display("FAIL first_pixel_latency: got valid=%b want 1", pix_valid); end
            end
        end
        tick(); tick();
        n_checks++;
        if (bus.mem_addr !== AW'(4) || bus.host_ready !== 1'b1) begin
            n_fail++; $display("FAIL burst_stall: got addr=%0d ready=%b want addr=4 ready=1", bus.mem_addr, bus.host_ready);
        end
    endtask

    task automatic test_line_pixels();
        consume(H_PIX, "line0_pixel");
        rd_cnt_en = 1'b0;
        n_checks++; if (pix_valid !== 1'b0 || pix !== 2'b11) begin n_fail++; $display("FAIL line_end_blank: got valid=%b pix=%b want 0/11", pix_valid, pix); end
        n_checks++; if (rd_cnt != BPL) begin n_fail++; $display("FAIL line_reads: got %0d want %0d", rd_cnt, BPL); end
        n_checks++; if (bus.mem_addr !== AW'(BPL - 1)) begin n_fail++; $display("FAIL line_last_addr: got %0d want %0d", bus.mem_addr, BPL - 1); end
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL line_underrun: got %b want 0", underrun); end
        n_checks++; if (exp_pix.size() != 0) begin n_fail++; $display("FAIL line_scoreboard_left: got %0d want 0", exp_pix.size()); end
    endtask

    task automatic test_host_write();
        int we_cnt = 0;
        logic accepted = 1'b0;
        start_line(8'd1, 1'b0);
        bus.host_valid = 1'b1; bus.host_addr = AW'(5); bus.host_data = 8'hA5;
        n_checks++; if (bus.host_ready !== 1'b0) begin n_fail++; $display("FAIL host_blocked_by_fetch: got ready=%b want 0", bus.host_ready); end
        for (int c = 0; c < 20; c++) begin
            if (bus.host_valid && bus.host_ready) begin
                exp_wr.push_back({bus.host_addr, bus.host_data});
                accepted = 1'b1;
            end
            tick();
            if (accepted) bus.host_valid = 1'b0;
            if (bus.mem_we) begin
                logic [AW+7:0] w;
                we_cnt++;
                w = (exp_wr.size() != 0) ? exp_wr.pop_front() : 'x;
                n_checks++;
                if ({bus.mem_addr, bus.mem_wdata} !== w) begin
                    n_fail++; $display("FAIL host_write_data: got addr=%0d data=%h want addr=%0d data=%h",
                                       bus.mem_addr, bus.mem_wdata, w[AW+7:8], w[7:0]);
                end
            end
        end
        n_checks++; if (we_cnt != 1 || !accepted) begin n_fail++; $display("FAIL host_write_count: got we=%0d acc=%b want 1/1", we_cnt, accepted); end
        n_checks++; if (exp_wr.size() != 0) begin n_fail++; $display("FAIL host_write_left: got %0d want 0", exp_wr.size()); end
    endtask

    task automatic test_host_oob();
        n_checks++; if (bus.host_ready !== 1'b1) begin n_fail++; $display("FAIL oob_ready: got %b want 1", bus.host_ready); end
        bus.host_valid = 1'b1; bus.host_addr = AW'(6400); bus.host_data = 8'h5A;
        tick();
        bus.host_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL oob_dropped[%0d]: got we=%b want 0", c, bus.mem_we); end
            tick();
        end
    endtask

    task automatic test_restart();
        ram[400] = 8'hFF;
        ram[440] = 8'b10_01_00_11;
        start_line(8'd10, 1'b0);
        tick();
        start_line(8'd11, 1'b0);
        tick();
        n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL stale_discarded: got valid=%b pix=%b want valid=0", pix_valid, pix); end
        tick(); tick();
        n_checks++; if (pix_valid !== 1'b1 || pix !== 2'b10) begin n_fail++; $display("FAIL restart_first_pixel: got valid=%b pix=%b want 1/10", pix_valid, pix); end
        consume(8, "line11_pixel");
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL restart_underrun: got %b want 0", underrun); end
    endtask

    task automatic test_blank_line_and_collision();
        start_line(8'd200, 1'b0);
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (bus.host_ready !== 1'b1 || pix_valid !== 1'b0) begin
                n_fail++; $display("FAIL blank_line_idle[%0d]: got ready=%b valid=%b want 1/0", c, bus.host_ready, pix_valid);
            end
            tick();
        end
        pix_adv = 1'b1; tick(); pix_adv = 1'b0; tick();
        n_checks++; if (underrun !== 1'b1 || pix !== 2'b11) begin n_fail++; $display("FAIL blank_underrun: got und=%b pix=%b want 1/11", underrun, pix); end
        // line_start wins over a same-cycle pix_adv: underrun is cleared, not set.
        start_line(8'd12, 1'b1);
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL line_start_wins: got und=%b want 0", underrun); end
`ifdef DMG_FB_STATS_EN
        n_checks++; if (underrun_cnt !== 16'd4) begin n_fail++; $display("FAIL underrun_cnt_total: got %0d want 4", underrun_cnt); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = 8'(i * 37 + 11);
        ram[0] = 8'b00011011;
        bus.host_valid = 1'b0; bus.host_addr = '0; bus.host_data = 8'h00;
        test_reset();
        test_underrun_no_line();
        test_fetch_burst();
        test_line_pixels();
        test_host_write();
        test_host_oob();
        test_restart();
        test_blank_line_and_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
